// File: rtl/wbm_desc_rd.sv
// -----------------------------------------------------------------------------
// wbm_desc_rd
//
// Wishbone master that fetches a short descriptor (1..16 consecutive 32-bit
// words) starting at an 8-byte aligned base address. Each returned word is
// presented on a one-cycle strobe with its index. Slave retries are re-issued
// after a one-cycle strobe-low gap, up to MAX_RTY times per word. A slave
// error, retry exhaustion or TMO_CYC silent bus cycles end the transfer with
// an error pulse and a sticky reason code. An abort request ends any transfer
// quietly.
//
// Parameters
//   TMO_CYC      silent BUS cycles tolerated before a timeout (1..255)
//   MAX_RTY      retries allowed per word before an error
//
// Ports
//   wb_clk_i     clock, all logic on the rising edge
//   wb_rst_i     synchronous reset, active low
//   req_i        start pulse, only honoured while idle
//   req_adr_i    descriptor base address bits [31:3]
//   req_len_i    word count minus one
//   abort_i      abandon the current transfer (wins over every bus event)
//   busy_o       transfer in progress
//   done_o       one-cycle pulse, all words delivered
//   err_o        one-cycle pulse, transfer failed
//   err_code_o   failure reason (1 bus error, 2 retries, 3 timeout), sticky
//                until the next accepted request
//   rd_vld_o     return-data strobe
//   rd_idx_o     index of the word on rd_dat_o
//   rd_dat_o     returned data word
//   wbm_*        Wishbone master request outputs / response inputs
// -----------------------------------------------------------------------------
module wbm_desc_rd #(
    parameter int unsigned TMO_CYC = 255,
    parameter int unsigned MAX_RTY = 3
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    input  logic        req_i,
    input  logic [31:3] req_adr_i,
    input  logic [3:0]  req_len_i,
    input  logic        abort_i,

    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [1:0]  err_code_o,

    output logic        rd_vld_o,
    output logic [3:0]  rd_idx_o,
    output logic [31:0] rd_dat_o,

    output logic [31:0] wbm_adr_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic        wbm_cab_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        wbm_rty_i
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUS     = 2'd1,
        ST_RTY_GAP = 2'd2,
        ST_ERR     = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        EC_NONE = 2'd0,
        EC_BUS  = 2'd1,
        EC_RTY  = 2'd2,
        EC_TMO  = 2'd3
    } err_code_t;

    localparam logic [7:0] LP_TMO_CYC = 8'(TMO_CYC);
    localparam logic [7:0] LP_MAX_RTY = 8'(MAX_RTY);

    state_t      r_state;
    logic [3:0]  r_len;
    logic [3:0]  r_word_cnt;
    logic [7:0]  r_rty_cnt;
    logic [7:0]  r_tmo_cnt;
    logic [31:0] r_adr;
    logic [3:0]  r_sel;
    logic        r_cyc;
    logic        r_stb;
    logic        r_cab;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    err_code_t   r_err_code;
    logic        r_rd_vld;
    logic [3:0]  r_rd_idx;
    logic [31:0] r_rd_dat;

    logic        w_last;
    logic [7:0]  w_tmo_nxt;
    logic        w_fail;
    err_code_t   w_fail_code;

    assign w_last    = (r_word_cnt == r_len);
    assign w_tmo_nxt = r_tmo_cnt + 8'd1;

    // Classify the terminating bus outcomes of this BUS cycle. The order
    // matches the response priority err > ack > rty; a silent cycle only
    // fails once it completes the timeout window.
    always_comb begin
        w_fail      = 1'b0;
        w_fail_code = EC_NONE;
        if (r_state == ST_BUS) begin
            if (wbm_err_i) begin
                w_fail      = 1'b1;
                w_fail_code = EC_BUS;
            end else if (!wbm_ack_i && wbm_rty_i) begin
                if (r_rty_cnt >= LP_MAX_RTY) begin
                    w_fail      = 1'b1;
                    w_fail_code = EC_RTY;
                end
            end else if (!wbm_ack_i && !wbm_rty_i) begin
                if (w_tmo_nxt == LP_TMO_CYC) begin
                    w_fail      = 1'b1;
                    w_fail_code = EC_TMO;
                end
            end
        end
    end

    // NOTE: every register below is updated with non-blocking assignments so
    // each branch sees the values from before this edge, independent of the
    // order the statements are written in.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            // NOTE: the design holds no memories, so every register is
            // reset; nothing here relies on power-up values.
            r_state    <= ST_IDLE;
            r_len      <= 4'd0;
            r_word_cnt <= 4'd0;
            r_rty_cnt  <= 8'd0;
            r_tmo_cnt  <= 8'd0;
            r_adr      <= 32'd0;
            r_sel      <= 4'd0;
            r_cyc      <= 1'b0;
            r_stb      <= 1'b0;
            r_cab      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= EC_NONE;
            r_rd_vld   <= 1'b0;
            r_rd_idx   <= 4'd0;
            r_rd_dat   <= 32'd0;
        end else begin
            // Pulsed outputs default low every cycle.
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_rd_vld <= 1'b0;

            if ((r_state != ST_IDLE) && abort_i) begin
                // Abort wins over anything the slave does this cycle; a
                // coincident ack is dropped along with the transfer.
                r_state <= ST_IDLE;
                r_cyc   <= 1'b0;
                r_stb   <= 1'b0;
                r_cab   <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (req_i) begin
                            r_len      <= req_len_i;
                            r_word_cnt <= 4'd0;
                            r_rty_cnt  <= 8'd0;
                            r_tmo_cnt  <= 8'd0;
                            r_err_code <= EC_NONE;
                            r_adr      <= {req_adr_i, 3'b000};
                            r_sel      <= 4'hF;
                            r_cyc      <= 1'b1;
                            r_stb      <= 1'b1;
                            r_cab      <= (req_len_i != 4'd0);
                            r_busy     <= 1'b1;
                            r_state    <= ST_BUS;
                        end
                    end

                    ST_BUS: begin
                        if (w_fail) begin
                            r_cyc      <= 1'b0;
                            r_stb      <= 1'b0;
                            r_cab      <= 1'b0;
                            r_err      <= 1'b1;
                            r_err_code <= w_fail_code;
                            r_state    <= ST_ERR;
                        end else if (wbm_ack_i) begin
                            r_rd_vld  <= 1'b1;
                            r_rd_idx  <= r_word_cnt;
                            r_rd_dat  <= wbm_dat_i;
                            r_rty_cnt <= 8'd0;
                            r_tmo_cnt <= 8'd0;
                            if (w_last) begin
                                r_done  <= 1'b1;
                                r_cyc   <= 1'b0;
                                r_stb   <= 1'b0;
                                r_cab   <= 1'b0;
                                r_busy  <= 1'b0;
                                r_state <= ST_IDLE;
                            end else begin
                                // Address advances by one word and wraps
                                // silently at the top of the 32-bit space.
                                r_word_cnt <= r_word_cnt + 4'd1;
                                r_adr      <= r_adr + 32'd4;
                            end
                        end else if (wbm_rty_i) begin
                            // Retry budget not yet spent (checked above):
                            // hold the cycle, drop the strobe for one cycle.
                            r_rty_cnt <= r_rty_cnt + 8'd1;
                            r_tmo_cnt <= 8'd0;
                            r_stb     <= 1'b0;
                            r_state   <= ST_RTY_GAP;
                        end else begin
                            r_tmo_cnt <= w_tmo_nxt;
                        end
                    end

                    ST_RTY_GAP: begin
                        // Re-issue the same word at the same address.
                        r_stb   <= 1'b1;
                        r_state <= ST_BUS;
                    end

                    ST_ERR: begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end

                    default: begin
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_cab   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign err_o      = r_err;
    assign err_code_o = r_err_code;
    assign rd_vld_o   = r_rd_vld;
    assign rd_idx_o   = r_rd_idx;
    assign rd_dat_o   = r_rd_dat;
    assign wbm_adr_o  = r_adr;
    assign wbm_sel_o  = r_sel;
    assign wbm_cyc_o  = r_cyc;
    assign wbm_stb_o  = r_stb;
    assign wbm_we_o   = 1'b0;
    assign wbm_cab_o  = r_cab;

endmodule

// File: doc/wbm_desc_rd.md
WBM_DESC_RD -- requirements
Module: wbm_desc_rd

Interface
REQ-001 The block SHALL have parameter TMO_CYC, default 255, giving the number of wait cycles without any response before a timeout (range 1..255).
REQ-002 The block SHALL have parameter MAX_RTY, default 3, giving the number of wbm_rty_i retries allowed per word before an error.
REQ-003 wb_clk_i  in  1  the single clock; all logic SHALL be rising-edge.
REQ-004 wb_rst_i  in  1  reset, synchronous and active-low.
REQ-005 req_i  in  1  start pulse; SHALL be sampled only when busy_o=0.
REQ-006 req_adr_i  in  29 [31:3]  descriptor base address, 8-byte aligned.
REQ-007 req_len_i  in  4  word count minus 1 (0 means 1 word, 15 means 16 words).
REQ-008 abort_i  in  1  abort request; SHALL take priority over every bus event in the same cycle.
REQ-009 busy_o  out  1  a transfer is in progress.
REQ-010 done_o  out  1  one-cycle pulse when all words complete.
REQ-011 err_o  out  1  one-cycle pulse on bus error, retry exhaustion or timeout.
REQ-012 err_code_o  out  2  reason for the error: 1=wbm_err_i, 2=retry exhausted, 3=timeout; held until the next req_i.
REQ-013 rd_vld_o / rd_idx_o[3:0] / rd_dat_o[31:0]  out  return-data strobe, word index and data word.
REQ-014 wbm_adr_o[31:0], wbm_sel_o[3:0], wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cab_o  out  Wishbone master request outputs.
REQ-015 wbm_dat_i[31:0], wbm_ack_i, wbm_err_i, wbm_rty_i  in  Wishbone master response inputs.

Function
REQ-016 States SHALL be IDLE, BUS, RTY_GAP, ERR.
REQ-017 IDLE with req_i=1: latch the address and length, clear word/retry/timeout counters, clear err_code_o, go to BUS next cycle.
REQ-018 BUS: cyc=stb=1, we=0, sel=4'hF, wbm_adr_o = {req_adr_i,3'b000} + 4*word_cnt, 32-bit wrap with no carry-out.
REQ-019 wbm_cab_o SHALL be 1 in BUS when req_len_i>0, otherwise 0.
REQ-020 wbm_ack_i in BUS: rd_vld_o=1 next cycle with rd_dat_o=wbm_dat_i and rd_idx_o=word_cnt; word_cnt increments; retry and timeout counters clear.
REQ-021 Ack of the last word (word_cnt==req_len_i): done_o pulse, drop cyc/stb in the same cycle as done_o, return to IDLE.
REQ-022 wbm_rty_i in BUS: if rty_cnt<MAX_RTY, increment rty_cnt, go to RTY_GAP (cyc=1, stb=0 for exactly one cycle), then return to BUS with the same address.
REQ-023 If rty_cnt==MAX_RTY when wbm_rty_i arrives, go to ERR with code 2.
REQ-024 wbm_err_i in BUS: go to ERR with code 1.
REQ-025 Response priority SHALL be err > ack > rty when several are asserted together.
REQ-026 Timeout: tmo_cnt increments on every BUS cycle with no response; at tmo_cnt==TMO_CYC go to ERR with code 3.
REQ-027 ERR: one cycle with cyc=stb=0, err_o=1, then IDLE.
REQ-028 No rd_vld_o SHALL be produced for an erroring word.
REQ-029 abort_i in any non-IDLE state: drop cyc/stb next cycle, go to IDLE with no done_o and no err_o; an ack in the same cycle SHALL be discarded.
REQ-030 busy_o SHALL be 1 in every state except IDLE.
REQ-031 req_i while busy_o=1 SHALL be ignored.
REQ-032 Latency: with zero-wait acks, an N-word read SHALL take N BUS cycles, and the first wbm_stb_o SHALL come 1 cycle after req_i.

Reset
REQ-033 While wb_rst_i=0 at a clock edge: state=IDLE; all counters 0; cyc, stb, we, cab, busy_o, done_o, err_o, rd_vld_o = 0; err_code_o=0; wbm_adr_o=0; wbm_sel_o=0; rd_idx_o=0; rd_dat_o=0.
REQ-034 Reset asserted mid-transfer SHALL drop cyc/stb at the next edge with no done_o or err_o.

Verification
REQ-035 req_adr=29'h2, len=3, slave acks every cycle -> addresses 0x10, 0x14, 0x18, 0x1C; rd_idx 0..3; done_o in the 4th BUS cycle; cab=1.
REQ-036 len=0, slave asserts rty twice then acks -> two RTY_GAP stb-low cycles, same address 0x10 reissued, one rd_vld_o, done_o, no err_o.
REQ-037 Slave asserts rty 4 times with MAX_RTY=3 -> err_o pulse, err_code_o=2, cyc low, no rd_vld_o.
REQ-038 Slave silent with TMO_CYC=4 -> err_code_o=3 after 4 BUS cycles; err and ack together on word 1 -> err_code_o=1 and only word 0 delivered.
REQ-039 Base 0xFFFFFFF8, len=2 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 (wrap).
REQ-040 abort_i coinciding with ack of word 1 -> no rd_vld_o for word 1, no done_o, busy_o=0 next cycle; req_i during busy -> ignored.
